// File: rtl/usb_tx_pkg.sv
// ----------------------------------------------------------------------------
// usb_tx_pkg
// Shared definitions for the USB transmit bit pipeline (packet sequencer,
// CRC generator and bit-stuffer).
//   tx_state_e   : packet sequencer FSM states
//   tx_phase_e   : field currently on the serial stream (NONE/SYNC/PID/DATA)
//   SYNC_PATTERN : SYNC byte, sent LSB first so the line sees 0000_0001
//   pid_byte()   : builds the PID byte {~pid, pid} from the PID nibble
// ----------------------------------------------------------------------------
package usb_tx_pkg;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_EOP  = 3'd4,
        ST_ERR  = 3'd5
    } tx_state_e;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_SYNC = 2'd1,
        PH_PID  = 2'd2,
        PH_DATA = 2'd3
    } tx_phase_e;

    // The upper nibble carries the check bits (one's complement of the PID).
    function automatic logic [7:0] pid_byte(input logic [3:0] pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/tx_byte_prefetch.sv
// ----------------------------------------------------------------------------
// tx_byte_prefetch
// One-byte prefetch buffer between the payload source and the sequencer's
// shift register.
//   clock, reset : clock and synchronous active-high reset
//   clear        : empties the buffer (used when a packet is aborted)
//   fill_en      : sequencer still wants bytes for the current packet
//   byte_in      : payload byte from the source
//   byte_valid   : byte_in is valid
//   byte_ready   : buffer can take a byte this cycle
//   drain        : sequencer consumes the buffered byte this cycle
//   full         : buffer holds a byte
//   buf_data     : buffered byte
// ----------------------------------------------------------------------------
module tx_byte_prefetch (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       fill_en,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       drain,
    output logic       full,
    output logic [7:0] buf_data
);

    logic       full_q;
    logic [7:0] data_q;
    logic       fill;

    assign byte_ready = fill_en & ~full_q;
    assign fill       = byte_valid & byte_ready;
    assign full       = full_q;
    assign buf_data   = data_q;

    // Fill wins over drain: a byte arriving in the same cycle as a drain
    // leaves the buffer full with the new byte.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            full_q <= 1'b0;
        end else if (fill) begin
            full_q <= 1'b1;
        end else if (drain) begin
            full_q <= 1'b0;
        end
    end

    // Payload storage carries no reset; full_q qualifies it.
    always_ff @(posedge clock) begin
        if (fill) begin
            data_q <= byte_in;
        end
    end

endmodule

// File: rtl/usb_tx_packet_sequencer.sv
// ----------------------------------------------------------------------------
// usb_tx_packet_sequencer
// Serialises one USB packet (SYNC, PID, payload bytes, LSB first) into the
// transmit bit pipeline and then requests EOP from the line driver.
//   clock, reset           : clock and synchronous active-high reset
//   pkt_start/pid/len      : packet request from the protocol handler
//   pkt_busy/done/err      : packet status back to the protocol handler
//   byte_in/valid/ready    : payload byte handshake (one-byte prefetch)
//   bs_ready               : downstream accepts the current bit (0 = hold)
//   out_bit/valid/phase    : serial bit stream and field tag for CRC/stuffer
//   eop_req                : one-cycle EOP request
// ----------------------------------------------------------------------------
module usb_tx_packet_sequencer
    import usb_tx_pkg::*;
#(
    parameter int MAX_BYTES = 64,
    parameter int LEN_W     = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pkt_start,
    input  logic [3:0]       pkt_pid,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             pkt_busy,
    output logic             pkt_done,
    output logic             pkt_err,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic             byte_ready,
    input  logic             bs_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic [1:0]       out_phase,
    output logic             eop_req
);

    tx_state_e        state_q;
    tx_phase_e        phase_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             eop_q;
    logic             valid_q;
    logic [2:0]       bit_cnt_q;
    logic [LEN_W-1:0] sent_cnt_q;
    logic [LEN_W-1:0] fetch_cnt_q;

    logic [7:0]       shreg_q;
    logic [3:0]       pid_q;
    logic [LEN_W-1:0] len_q;

    logic             len_bad;
    logic             start_ok;
    logic             adv;
    logic             byte_end;
    logic             sync_last;
    logic             need_byte;
    logic             drain;
    logic             fetch_en;
    logic             fill;
    logic             buf_clear;
    logic             buf_full;
    logic [7:0]       buf_data;

    assign len_bad   = (pkt_len > LEN_W'(MAX_BYTES));
    assign start_ok  = (state_q == ST_IDLE) && pkt_start && !len_bad;

    // A bit only moves when it is on the wire and downstream takes it.
    assign adv       = valid_q & bs_ready;
    assign byte_end  = adv && (bit_cnt_q == 3'd7);
    assign sync_last = byte_end && (state_q == ST_SYNC);

    // Byte boundaries that must pull the next payload byte from the buffer:
    // end of PID with a non-empty payload, or end of a non-final data byte.
    assign need_byte = byte_end &&
                       (((state_q == ST_PID)  && (len_q != '0)) ||
                        ((state_q == ST_DATA) && (sent_cnt_q != len_q)));
    assign drain     = need_byte & buf_full;

    // Fetching stops once every payload byte has been taken; EOP/ERR never
    // accept bytes because the buffer is about to be abandoned.
    assign fetch_en  = busy_q &&
                       ((state_q == ST_SYNC) || (state_q == ST_PID) ||
                        (state_q == ST_DATA)) &&
                       (fetch_cnt_q < len_q);
    assign fill      = byte_valid & byte_ready;
    assign buf_clear = (state_q == ST_ERR);

    tx_byte_prefetch u_prefetch (
        .clock      (clock),
        .reset      (reset),
        .clear      (buf_clear),
        .fill_en    (fetch_en),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .drain      (drain),
        .full       (buf_full),
        .buf_data   (buf_data)
    );

    // Control FSM, counters and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_NONE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            eop_q       <= 1'b0;
            valid_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            sent_cnt_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            eop_q  <= 1'b0;

            if (fill) begin
                fetch_cnt_q <= fetch_cnt_q + LEN_W'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (pkt_start) begin
                        busy_q <= 1'b1;
                        if (len_bad) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q     <= ST_SYNC;
                            phase_q     <= PH_SYNC;
                            valid_q     <= 1'b1;
                            bit_cnt_q   <= 3'd0;
                            sent_cnt_q  <= '0;
                            fetch_cnt_q <= '0;
                        end
                    end
                end

                ST_SYNC: begin
                    if (adv) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PID;
                            phase_q <= PH_PID;
                        end
                    end
                end

                ST_PID: begin
                    if (adv) begin
                        if (bit_cnt_q != 3'd7) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (len_q == '0) begin
                            state_q <= ST_EOP;
                            phase_q <= PH_NONE;
                            valid_q <= 1'b0;
                            eop_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (buf_full) begin
                            state_q    <= ST_DATA;
                            phase_q    <= PH_DATA;
                            bit_cnt_q  <= 3'd0;
                            sent_cnt_q <= sent_cnt_q + LEN_W'(1);
                        end else begin
                            state_q <= ST_ERR;
                            phase_q <= PH_NONE;
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (adv) begin
                        if (bit_cnt_q != 3'd7) begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end else if (sent_cnt_q == len_q) begin
                            state_q <= ST_EOP;
                            phase_q <= PH_NONE;
                            valid_q <= 1'b0;
                            eop_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else if (buf_full) begin
                            bit_cnt_q  <= 3'd0;
                            sent_cnt_q <= sent_cnt_q + LEN_W'(1);
                        end else begin
                            // Starved at a byte boundary: abort without
                            // advancing the bit.
                            state_q <= ST_ERR;
                            phase_q <= PH_NONE;
                            valid_q <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                end

                ST_EOP, ST_ERR: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                    phase_q <= PH_NONE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Serial datapath: the shift register always presents the current bit
    // in bit 0 and is reloaded at each field/byte boundary.
    always_ff @(posedge clock) begin
        if (start_ok) begin
            shreg_q <= SYNC_PATTERN;
            pid_q   <= pkt_pid;
            len_q   <= pkt_len;
        end else if (sync_last) begin
            shreg_q <= pid_byte(pid_q);
        end else if (drain) begin
            shreg_q <= buf_data;
        end else if (adv) begin
            shreg_q <= {1'b0, shreg_q[7:1]};
        end
    end

    assign pkt_busy  = busy_q;
    assign pkt_done  = done_q;
    assign pkt_err   = err_q;
    assign eop_req   = eop_q;
    assign out_valid = valid_q;
    assign out_phase = phase_q;
    // Gating with valid keeps the unreset shift register off the line.
    assign out_bit   = valid_q & shreg_q[0];

endmodule
